mul_long_seq: RTL
=================

// Module: mul_long_seq
// PURPOSE
//  Multi-cycle sequencer wrapped around the 32x32 combinational multiplier (low 32 bits of the product only).
//  Captures operands from the register-read stage and drives the multiplier's Rm/Rs inputs.
//  Accumulates partial products into the 64-bit result for MUL, MLA, UMULL/UMLAL and SMULL/SMLAL.
//  Produces RdLo/RdHi write-back data plus N/Z flags.
//  The multiplier is instantiated in the parent; this block sits on both its input side and its output side.
// PARAMETERS
//  N      32  operand width; only 32 is supported (halves are N/2 = 16)
// PORTS
//  clk       in   1   single clock, rising edge
//  rst_n     in   1   asynchronous, active-low reset
//  start     in   1   request; sampled only in IDLE
//  long_en   in   1   1 = 64-bit (UMULL/SMULL family), 0 = 32-bit MUL/MLA
//  signed_en in   1   1 = signed long multiply; ignored when long_en=0
//  acc_en    in   1   1 = accumulate (MLA/UMLAL/SMLAL)
//  rm, rs    in   32  multiplicand / multiplier operands
//  acc_lo    in   32  Rn (MLA) or RdLo (xMLAL) accumulate input
//  acc_hi    in   32  RdHi accumulate input; used only when long_en=1
//  mul_a     out  32  to multiplier Rm
//  mul_b     out  32  to multiplier Rs
//  mul_p     in   32  from multiplier result; combinational from mul_a/mul_b in the same cycle
//  busy      out  1   state != IDLE
//  done      out  1   one-cycle pulse; res_* and flags are valid from this cycle
//  res_lo    out  32  result bits [31:0]
//  res_hi    out  32  result bits [63:32]; 0 when long_en=0
//  n_flag    out  1   result sign bit
//  z_flag    out  1   result == 0
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, res_lo, res_hi, n_flag, z_flag, mul_a, mul_b all 0.
//  Reset mid-operation aborts the operation: no done pulse, and results are cleared.
//  FSM states: IDLE -> PP (2-bit index k) -> FIN -> IDLE.
//  IDLE:
//   - On start=1, latch rm, rs, acc_lo, acc_hi and the mode bits; clear the 64-bit accumulator prod; set k=0; go to PP.
//   - start while busy is ignored; no queueing.
//  Operand magnitudes (long signed only):
//   - a = |rm|, b = |rs|, computed as unsigned 32-bit; 0x80000000 maps to 0x80000000.
//   - neg = rm[31] ^ rs[31].
//   - Otherwise a = rm, b = rs, neg = 0.
//  PP, short mode (long_en=0): one cycle; mul_a=a, mul_b=b; prod[31:0] <= mul_p; go to FIN.
//  PP, long mode: four cycles. In each, mul_a/mul_b are zero-extended 16-bit halves and prod += mul_p << shift:
//   - k=0: a_lo*b_lo, shift 0
//   - k=1: a_lo*b_hi, shift 16
//   - k=2: a_hi*b_lo, shift 16
//   - k=3: a_hi*b_hi, shift 32; then go to FIN
//  All additions are modulo 2^64; each 16x16 product fits in 32 bits, so nothing is lost.
//  FIN: p = neg ? (~prod + 1) : prod.
//   - long_en=1: r = p + (acc_en ? {acc_hi,acc_lo} : 0), modulo 2^64.
//   - long_en=0: r_lo = p[31:0] + (acc_en ? acc_lo : 0), modulo 2^32; r_hi = 0.
//   - Register res_*, n_flag and z_flag; pulse done next cycle; go to IDLE.
//  Flags:
//   - n_flag = long_en ? r[63] : r[31].
//   - z_flag = (long_en ? r[63:0] : r[31:0]) == 0.
//   - C and V are not produced (unpredictable in ARMv4 multiply).
//  Latency from the start-sampling edge to done high: short = 2 cycles, long = 5 cycles.
//  In the done cycle the state is already IDLE, so a new start is accepted (back-to-back issue).
//  res_* and flags hold until the next completion or reset. mul_a/mul_b = 0 in IDLE and FIN.
// STRUCTURE
//  Package arm_mul_pkg holds:
//   - state enum {IDLE, PP, FIN}
//   - constants MUL_HALF=16 and PP_LAST=2'd3
//   - shift table per k {0,16,16,32}
//  No sub-module: the multiplier is instantiated beside this block in the parent, wired mul_a->Rm, mul_b->Rs, result->mul_p.
//  The bench instantiates both blocks together.
// TESTING
//  1. MUL rm=7, rs=6 -> res_lo=42, res_hi=0, N=0, Z=0; done exactly 2 cycles after start; busy high 2 cycles.
//  2. MLA rm=0xFFFFFFFF, rs=2, acc_lo=3 -> res_lo=0x00000001 (wrap), res_hi=0.
//  3. UMULL rm=rs=0xFFFFFFFF -> res_hi=0xFFFFFFFE, res_lo=0x00000001; done 5 cycles after start; mul_a/mul_b show the four half pairs in order.
//  4. SMULL rm=0xFFFFFFFE, rs=3 -> 0xFFFFFFFF_FFFFFFFA, N=1. SMULL rm=rs=0x80000000 -> 0x40000000_00000000, N=0.
//  5. SMLAL rm=0xFFFFFFFF, rs=1, acc={0,1} -> res=0, Z=1, N=0.
//  6. Control checks:
//   - start held high while busy -> ignored, one done only.
//   - start in the done cycle -> second op accepted, results correct.
//   - rst_n low during PP k=2 -> busy=0 and outputs 0 immediately; no done.

Source files
------------

// File: rtl/arm_mul_pkg.sv
// ============================================================================
//  Module      : arm_mul_pkg
//  Description : Shared types, constants and helpers for the multi-cycle
//                long-multiply sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arm_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PP   = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam int         MUL_HALF = 16;
    localparam logic [1:0] PP_LAST  = 2'd3;

    // Weight of each 16x16 partial product: lo*lo, lo*hi, hi*lo, hi*hi.
    function automatic logic [5:0] pp_shift(input logic [1:0] k);
        case (k)
            2'd0:    pp_shift = 6'd0;
            2'd1:    pp_shift = 6'd16;
            2'd2:    pp_shift = 6'd16;
            default: pp_shift = 6'd32;
        endcase
    endfunction

    function automatic logic [31:0] pp_half(input logic [31:0] x, input logic hi);
        pp_half = hi ? {16'd0, x[31:MUL_HALF]} : {16'd0, x[MUL_HALF-1:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mul_long_seq.sv
// ============================================================================
//  Module      : mul_long_seq
//  Description : Sequencer around an external 32x32 (low-32) multiplier that
//                builds MUL/MLA and 64-bit UMULL/UMLAL/SMULL/SMLAL results.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_long_seq
    import arm_mul_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         long_en,
    input  logic         signed_en,
    input  logic         acc_en,
    input  logic [N-1:0] rm,
    input  logic [N-1:0] rs,
    input  logic [N-1:0] acc_lo,
    input  logic [N-1:0] acc_hi,
    output logic [N-1:0] mul_a,
    output logic [N-1:0] mul_b,
    input  logic [N-1:0] mul_p,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] res_lo,
    output logic [N-1:0] res_hi,
    output logic         n_flag,
    output logic         z_flag
);

    state_t         state_q, state_d;
    logic [1:0]     k_q, k_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d;
    logic           neg_q, neg_d, long_q, long_d, acc_en_q, acc_en_d;
    logic [N-1:0]   acc_lo_q, acc_lo_d, acc_hi_q, acc_hi_d;
    logic [2*N-1:0] prod_q, prod_d;
    logic [N-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [N-1:0]   res_lo_q, res_lo_d, res_hi_q, res_hi_d;
    logic           n_q, n_d, z_q, z_d, done_q, done_d;

    logic           w_sgn;
    logic [N-1:0]   w_a_in, w_b_in;
    logic           w_neg_in;
    logic [1:0]     w_k_next;
    logic [2*N-1:0] w_p, w_r_long;
    logic [N-1:0]   w_r_short;

    // Signed long multiplies run on magnitudes; the sign is restored in FIN.
    assign w_sgn     = long_en & signed_en;
    assign w_a_in    = (w_sgn && rm[N-1]) ? (~rm + 1'b1) : rm;
    assign w_b_in    = (w_sgn && rs[N-1]) ? (~rs + 1'b1) : rs;
    assign w_neg_in  = w_sgn & (rm[N-1] ^ rs[N-1]);
    assign w_k_next  = k_q + 2'd1;

    assign w_p       = neg_q ? (~prod_q + 1'b1) : prod_q;
    assign w_r_long  = w_p + (acc_en_q ? {acc_hi_q, acc_lo_q} : {2*N{1'b0}});
    assign w_r_short = w_p[N-1:0] + (acc_en_q ? acc_lo_q : {N{1'b0}});

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        long_d   = long_q;
        acc_en_d = acc_en_q;
        acc_lo_d = acc_lo_q;
        acc_hi_d = acc_hi_q;
        prod_d   = prod_q;
        mul_a_d  = '0;
        mul_b_d  = '0;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        n_d      = n_q;
        z_d      = z_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d      = w_a_in;
                    b_d      = w_b_in;
                    neg_d    = w_neg_in;
                    long_d   = long_en;
                    acc_en_d = acc_en;
                    acc_lo_d = acc_lo;
                    acc_hi_d = acc_hi;
                    prod_d   = '0;
                    k_d      = 2'd0;
                    state_d  = ST_PP;
                    // Operands are registered one cycle ahead of their PP step.
                    mul_a_d  = long_en ? pp_half(w_a_in, 1'b0) : w_a_in;
                    mul_b_d  = long_en ? pp_half(w_b_in, 1'b0) : w_b_in;
                end
            end
            ST_PP: begin
                if (long_q) begin
                    prod_d = prod_q + ({{N{1'b0}}, mul_p} << pp_shift(k_q));
                    if (k_q == PP_LAST) begin
                        state_d = ST_FIN;
                    end else begin
                        k_d     = w_k_next;
                        mul_a_d = pp_half(a_q, w_k_next[1]);
                        mul_b_d = pp_half(b_q, w_k_next[0]);
                    end
                end else begin
                    prod_d  = {{N{1'b0}}, mul_p};
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                if (long_q) begin
                    res_lo_d = w_r_long[N-1:0];
                    res_hi_d = w_r_long[2*N-1:N];
                    n_d      = w_r_long[2*N-1];
                    z_d      = (w_r_long == '0);
                end else begin
                    res_lo_d = w_r_short;
                    res_hi_d = '0;
                    n_d      = w_r_short[N-1];
                    z_d      = (w_r_short == '0);
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            long_q   <= 1'b0;
            acc_en_q <= 1'b0;
            acc_lo_q <= '0;
            acc_hi_q <= '0;
            prod_q   <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            long_q   <= long_d;
            acc_en_q <= acc_en_d;
            acc_lo_q <= acc_lo_d;
            acc_hi_q <= acc_hi_d;
            prod_q   <= prod_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            n_q      <= n_d;
            z_q      <= z_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign mul_a  = mul_a_q;
    assign mul_b  = mul_b_q;
    assign res_lo = res_lo_q;
    assign res_hi = res_hi_q;
    assign n_flag = n_q;
    assign z_flag = z_q;

endmodule

`default_nettype wire
